// File: rtl/insn_line_buffer_pkg.sv
// Shared types and sizing helpers for the instruction line buffer.
package insn_line_buffer_pkg;

    localparam int LINE_BYTES = 16;
    localparam int LINE_W     = 128;
    localparam int OFFS_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ilb_state_e;

    // Control flops grouped so the FSM state is visible as one struct.
    typedef struct packed {
        ilb_state_e state;
        logic       drop;
    } ilb_ctrl_t;

    function automatic int idx_w(input int nlines);
        return (nlines > 1) ? $clog2(nlines) : 1;
    endfunction

    function automatic int tag_w(input int nlines, input int addr_w);
        return addr_w - OFFS_W - idx_w(nlines);
    endfunction

endpackage

// File: rtl/insn_line_store.sv
// Direct-mapped line store: data/tag/valid arrays, one combinational read
// port, one write port and a global invalidate that beats a same-cycle write.
module insn_line_store
    import insn_line_buffer_pkg::*;
#(
    parameter int NLINES = 4,
    parameter int ADDR_W = 32,
    localparam int IDXW  = idx_w(NLINES),
    localparam int TAGW  = tag_w(NLINES, ADDR_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDXW-1:0]   rd_idx,
    output logic              rd_valid,
    output logic [TAGW-1:0]   rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDXW-1:0]   wr_idx,
    input  logic [TAGW-1:0]   wr_tag,
    input  logic [LINE_W-1:0] wr_data,
    input  logic              inv_all
);

    logic [NLINES-1:0] valid_q, valid_d;
    logic [LINE_W-1:0] data_q [NLINES];
    logic [LINE_W-1:0] data_d [NLINES];
    logic [TAGW-1:0]   tag_q  [NLINES];
    logic [TAGW-1:0]   tag_d  [NLINES];

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (wr_en) begin
            data_d[wr_idx]  = wr_data;
            tag_d[wr_idx]   = wr_tag;
            valid_d[wr_idx] = 1'b1;
        end
        if (inv_all) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/insn_line_buffer.sv
// Instruction line buffer: zero-latency hit path plus a single-outstanding
// line fill FSM. Optional counters enabled by INSN_LINE_BUFFER_STATS_EN.
module insn_line_buffer
    import insn_line_buffer_pkg::*;
#(
    parameter int NLINES = 4,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_flush,
    output logic [LINE_W-1:0] o_insn_data,
    output logic              o_stall,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ready,
    input  logic              i_mem_rvalid,
    input  logic [LINE_W-1:0] i_mem_rdata
`ifdef INSN_LINE_BUFFER_STATS_EN
    ,
    output logic [31:0]       o_hit_cnt,
    output logic [31:0]       o_miss_cnt
`endif
);

    localparam int IDXW = idx_w(NLINES);
    localparam int TAGW = tag_w(NLINES, ADDR_W);
    localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'(LINE_BYTES - 1);

    ilb_ctrl_t         ctrl_q, ctrl_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic              fill_wr;
    logic              miss_start;
    logic              hit;

    logic [IDXW-1:0]   req_idx;
    logic [TAGW-1:0]   req_tag;
    logic              rd_valid;
    logic [TAGW-1:0]   rd_tag;
    logic [LINE_W-1:0] rd_data;

    assign req_idx = i_req_addr[OFFS_W+IDXW-1:OFFS_W];
    assign req_tag = i_req_addr[ADDR_W-1:OFFS_W+IDXW];

    insn_line_store #(
        .NLINES (NLINES),
        .ADDR_W (ADDR_W)
    ) u_store (
        .clk      (CLK),
        .rst_n    (RST_X),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_wr),
        .wr_idx   (fill_addr_q[OFFS_W+IDXW-1:OFFS_W]),
        .wr_tag   (fill_addr_q[ADDR_W-1:OFFS_W+IDXW]),
        .wr_data  (i_mem_rdata),
        .inv_all  (i_flush)
    );

    // A flush cycle never reports a hit, even for a line still marked valid.
    assign hit        = i_req_valid & ~i_flush & rd_valid & (rd_tag == req_tag);
    assign miss_start = (ctrl_q.state == IDLE) & i_req_valid & ~hit & ~i_flush;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            ctrl_q      <= '{state: IDLE, drop: 1'b0};
            fill_addr_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            fill_addr_q <= fill_addr_d;
        end
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        fill_addr_d = fill_addr_q;
        fill_wr     = 1'b0;
        case (ctrl_q.state)
            IDLE: begin
                if (miss_start) begin
                    ctrl_d.state = REQ;
                    fill_addr_d  = i_req_addr & ~OFFS_MASK;
                end
            end
            REQ: begin
                if (i_mem_ready) begin
                    ctrl_d.state = WAIT;
                end
                if (i_flush) begin
                    ctrl_d.drop = 1'b1;
                end
            end
            WAIT: begin
                // A flush anywhere in the fill's lifetime poisons its data.
                if (i_mem_rvalid) begin
                    ctrl_d.state = IDLE;
                    ctrl_d.drop  = 1'b0;
                    fill_wr      = ~ctrl_q.drop & ~i_flush;
                end else if (i_flush) begin
                    ctrl_d.drop = 1'b1;
                end
            end
            default: begin
                ctrl_d.state = IDLE;
                ctrl_d.drop  = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_mem_req   = (ctrl_q.state == REQ);
        o_mem_addr  = fill_addr_q;
        o_stall     = i_req_valid & ~hit;
        o_insn_data = hit ? rd_data : '0;
    end

`ifdef INSN_LINE_BUFFER_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (i_flush) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else begin
            if (hit && (hit_cnt_q != '1)) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
            if (miss_start && (miss_cnt_q != '1)) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign o_hit_cnt  = hit_cnt_q;
    assign o_miss_cnt = miss_cnt_q;
`endif

endmodule
